// File: rtl/cmd_parser_if.sv
// cmd_parser_if -- command parser bus bundle.
//   rx_byte   : received UART byte, 0x00 = idle line
//   act_ready : pet core accepts the current action
//   act_valid : action request
//   act_code  : 1 feed, 2 play, 3 clean, 4 sleep toggle, 5 medicine
//   busy      : parser not idle
//   err       : one-cycle protocol error pulse
// master = byte source / action sink, slave = the parser.
interface cmd_parser_if;
  logic [7:0] rx_byte;
  logic       act_ready;
  logic       act_valid;
  logic [2:0] act_code;
  logic       busy;
  logic       err;

  modport master (output rx_byte, output act_ready,
                  input  act_valid, input act_code, input busy, input err);
  modport slave  (input  rx_byte, input  act_ready,
                  output act_valid, output act_code, output busy, output err);
endinterface

// File: rtl/cmd_parser.sv
// cmd_parser -- turns ASCII commands ("<letter>[1-9]<CR|LF>") into repeated
// action handshakes towards the pet core.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : cmd_parser_if.slave (rx_byte, act_ready in; act_valid, act_code,
//          busy, err out)
// Parameter TIMEOUT_CYCLES: inter-byte timeout in clk cycles (2..2^25-1).
// Optional feature: define CMD_PARSER_TIMEOUT_EN to build the inter-byte
// timeout; without it CMD/CNT/DISCARD wait forever.
module cmd_parser #(
  parameter int TIMEOUT_CYCLES = 27000000
) (
  input logic         clk,
  input logic         rst,
  cmd_parser_if.slave bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 33554431) begin : g_bad_timeout
    $error("cmd_parser: TIMEOUT_CYCLES out of range 2..2^25-1");
  end

  typedef enum logic [2:0] {IDLE, CMD, CNT, DISCARD, ISSUE} state_t;

  state_t     state, state_n;
  logic [7:0] prev_byte;
  logic [3:0] count, count_n;
  logic [2:0] code, code_n;
  logic       err_q, err_n;

  // Byte cycle: first cycle of a non-zero byte after an idle (0x00) line.
  logic byte_cyc;
  assign byte_cyc = (bus.rx_byte != 8'h00) && (prev_byte == 8'h00);

  // Letters are case-folded; digits are matched on the raw byte because
  // clearing bit 5 would move them out of the ASCII digit range.
  logic [7:0] folded;
  logic [2:0] letter;
  logic       is_digit, is_term;
  assign folded   = bus.rx_byte & 8'hDF;
  assign is_digit = (bus.rx_byte >= 8'h31) && (bus.rx_byte <= 8'h39);
  assign is_term  = (bus.rx_byte == 8'h0D) || (bus.rx_byte == 8'h0A);

  always_comb begin
    letter = 3'd0;
    case (folded)
      8'h46:   letter = 3'd1; // F
      8'h50:   letter = 3'd2; // P
      8'h43:   letter = 3'd3; // C
      8'h53:   letter = 3'd4; // S
      8'h4D:   letter = 3'd5; // M
      default: letter = 3'd0;
    endcase
  end

  logic hs;
  assign hs = (state == ISSUE) && bus.act_ready;

`ifdef CMD_PARSER_TIMEOUT_EN
  logic [24:0] tmo_cnt;
  logic        tmo_act, tmo_hit;
  assign tmo_act = (state == CMD) || (state == CNT) || (state == DISCARD);
  // Fires TIMEOUT_CYCLES cycles after the byte cycle that entered/refreshed
  // the state; a byte arriving in the same cycle wins.
  assign tmo_hit = tmo_act && !byte_cyc && (tmo_cnt == 25'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                            tmo_cnt <= '0;
    else if (tmo_act && !byte_cyc && !tmo_hit) tmo_cnt <= tmo_cnt + 25'd1;
    else                                tmo_cnt <= '0;
  end
`endif

  always_comb begin
    state_n = state;
    count_n = count;
    code_n  = code;
    err_n   = 1'b0;
    case (state)
      IDLE: if (byte_cyc) begin
        if (letter != 3'd0) begin
          code_n  = letter;
          count_n = 4'd1;
          state_n = CMD;
        end else if (!is_term) begin
          err_n   = 1'b1;
          state_n = DISCARD;
        end
      end
      CMD: if (byte_cyc) begin
        if (is_digit) begin
          count_n = bus.rx_byte[3:0];
          state_n = CNT;
        end else if (is_term) begin
          state_n = ISSUE;
        end else begin
          err_n   = 1'b1;
          state_n = DISCARD;
        end
      end
      CNT: if (byte_cyc) begin
        if (is_term) state_n = ISSUE;
        else begin
          err_n   = 1'b1;
          state_n = DISCARD;
        end
      end
      DISCARD: if (byte_cyc && is_term) state_n = IDLE;
      ISSUE: begin
        // Bytes arriving mid-issue are dropped and flagged.
        if (byte_cyc) err_n = 1'b1;
        if (hs) begin
          count_n = count - 4'd1;
          if (count == 4'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef CMD_PARSER_TIMEOUT_EN
    if (tmo_hit) begin
      state_n = IDLE;
      err_n   = (state != DISCARD);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prev_byte <= 8'h00;
      count     <= 4'd0;
      code      <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      prev_byte <= bus.rx_byte;
      count     <= count_n;
      code      <= code_n;
      err_q     <= err_n;
    end
  end

  assign bus.act_valid = (state == ISSUE);
  assign bus.act_code  = (state == ISSUE) ? code : 3'd0;
  assign bus.busy      = (state != IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser -- scoreboard bench for cmd_parser. Expected action codes are
// queued when a command is sent and popped on each observed handshake.
module tb_cmd_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_parser_if bus();

`ifdef CMD_PARSER_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 27000000;
`endif

  cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int hs_cnt  = 0;
  int err_cnt = 0;
  logic [2:0] exp_q[$];

  // Monitor: samples just after the negedge, once this cycle's inputs are
  // driven, so valid&ready here is the handshake taken at the next posedge.
  logic       pv = 1'b0, pr = 1'b0, pe = 1'b0;
  logic [2:0] pc = 3'd0;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      pv = 1'b0; pr = 1'b0; pe = 1'b0;
    end else begin
      total++;
      if (!bus.act_valid && bus.act_code !== 3'd0) begin
        bad++; $display("FAIL code_idle: act_code=%0d required 0", bus.act_code);
      end
      if (pv && !pr) begin
        total++;
        if (bus.act_valid !== 1'b1 || bus.act_code !== pc) begin
          bad++; $display("FAIL valid_hold: valid=%0b code=%0d required 1/%0d", bus.act_valid, bus.act_code, pc);
        end
      end
      if (bus.act_valid && bus.act_ready) begin
        logic [2:0] e;
        hs_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL extra_hs: code=%0d with nothing expected", bus.act_code);
        end else begin
          e = exp_q.pop_front();
          if (bus.act_code !== e) begin
            bad++; $display("FAIL hs_code: got %0d required %0d", bus.act_code, e);
          end
        end
      end
      if (bus.err === 1'b1) err_cnt++;
      if (bus.err === 1'b1 && pe) begin
        total++; bad++; $display("FAIL err_width: err high 2 cycles, required 1");
      end
      pv = bus.act_valid; pr = bus.act_ready; pc = bus.act_code; pe = bus.err;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte = b;
    @(negedge clk);
    bus.rx_byte = 8'h00;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget, input bit rnd);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      if (rnd) bus.act_ready = 1'($urandom_range(0, 1));
      n++;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", name, bus.busy, budget);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++; $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.rx_byte = 8'h00; bus.act_ready = 1'b0;
    idle_cycles(3);
    total++;
    if (bus.act_valid !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.act_code !== 3'd0) begin
      bad++; $display("FAIL reset_out: valid=%0b busy=%0b err=%0b code=%0d required 0/0/0/0",
                      bus.act_valid, bus.busy, bus.err, bus.act_code);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // "F" CR with ready high: exactly one cycle of act_valid, right after CR.
  task automatic test_single;
    int h0 = hs_cnt;
    bus.act_ready = 1'b1;
    exp_q.push_back(3'd1);
    send_byte("F");
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy: busy=%0b required 1", bus.busy); end
    bus.rx_byte = 8'h0D;
    @(negedge clk);
    bus.rx_byte = 8'h00;
    total++;
    if (bus.act_valid !== 1'b1 || bus.act_code !== 3'd1) begin
      bad++; $display("FAIL single_rise: valid=%0b code=%0d required 1/1", bus.act_valid, bus.act_code);
    end
    @(negedge clk);
    total++;
    if (bus.act_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL single_fall: valid=%0b busy=%0b required 0/0", bus.act_valid, bus.busy);
    end
    check_int("single_hs", hs_cnt - h0, 1);
  endtask

  // "p3" LF with backpressure: valid and code must hold while stalled.
  task automatic test_hold;
    int h0 = hs_cnt;
    bus.act_ready = 1'b0;
    repeat (3) exp_q.push_back(3'd2);
    send_byte("p"); send_byte("3"); send_byte(8'h0A);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.act_valid !== 1'b1 || bus.act_code !== 3'd2) begin
        bad++; $display("FAIL hold_stall: valid=%0b code=%0d required 1/2", bus.act_valid, bus.act_code);
      end
      @(negedge clk);
    end
    bus.act_ready = 1'b1;
    wait_idle("hold", 20, 1'b0);
    check_int("hold_hs", hs_cnt - h0, 3);
    check_int("hold_q", exp_q.size(), 0);
  endtask

  task automatic test_error;
    int h0 = hs_cnt;
    int e0 = err_cnt;
    bus.act_ready = 1'b1;
    send_byte("X");
    idle_cycles(2);
    check_int("err_x", err_cnt - e0, 1);
    send_byte("F"); send_byte(8'h0D);
    idle_cycles(3);
    check_int("err_discard_hs", hs_cnt - h0, 0);
    check_int("err_discard_busy", int'(bus.busy), 0);
    exp_q.push_back(3'd3);
    send_byte("c"); send_byte(8'h0D);
    wait_idle("err_recover", 20, 1'b0);
    check_int("err_recover_hs", hs_cnt - h0, 1);
    check_int("err_recover_err", err_cnt - e0, 1);
  endtask

  task automatic test_reset_mid;
    int h0 = hs_cnt;
    int e0 = err_cnt;
    bus.act_ready = 1'b1;
    send_byte("s"); send_byte("2");
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    send_byte(8'h0D);
    idle_cycles(4);
    check_int("rstmid_hs", hs_cnt - h0, 0);
    check_int("rstmid_err", err_cnt - e0, 0);
    check_int("rstmid_busy", int'(bus.busy), 0);
    // Reset during ISSUE abandons the remaining repeats.
    bus.act_ready = 1'b0;
    send_byte("F"); send_byte("5"); send_byte(8'h0D);
    check_int("rstissue_valid", int'(bus.act_valid), 1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus.act_ready = 1'b1;
    idle_cycles(8);
    check_int("rstissue_hs", hs_cnt - h0, 0);
    check_int("rstissue_busy", int'(bus.busy), 0);
  endtask

  // "M9" CR, then "F" while issuing: err, 9 handshakes, F not retained.
  task automatic test_issue_drop;
    int h0 = hs_cnt;
    int e0 = err_cnt;
    bus.act_ready = 1'b0;
    repeat (9) exp_q.push_back(3'd5);
    send_byte("M"); send_byte("9"); send_byte(8'h0D);
    send_byte("F");
    idle_cycles(1);
    check_int("drop_err", err_cnt - e0, 1);
    check_int("drop_still_issue", int'(bus.act_valid), 1);
    bus.act_ready = 1'b1;
    wait_idle("drop", 40, 1'b0);
    check_int("drop_hs", hs_cnt - h0, 9);
    send_byte(8'h0D);
    idle_cycles(3);
    check_int("drop_f_gone", hs_cnt - h0, 9);
    check_int("drop_q", exp_q.size(), 0);
  endtask

  // Random letters/case/counts/terminators, random ready.
  task automatic test_back_to_back;
    logic [7:0] letters[5];
    int h0 = hs_cnt;
    int want = 0;
    letters = '{"F", "P", "C", "S", "M"};
    for (int k = 0; k < 12; k++) begin
      int li = $urandom_range(0, 4);
      int n  = $urandom_range(0, 9);
      logic [7:0] ch = letters[li];
      if ($urandom_range(0, 1) == 1) ch = ch | 8'h20;
      repeat ((n == 0) ? 1 : n) exp_q.push_back(3'(li + 1));
      want += (n == 0) ? 1 : n;
      send_byte(ch);
      if (n != 0) send_byte(8'h30 + 8'(n));
      send_byte(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
      wait_idle("b2b", 200, 1'b1);
    end
    check_int("b2b_hs", hs_cnt - h0, want);
    check_int("b2b_q", exp_q.size(), 0);
  endtask

`ifdef CMD_PARSER_TIMEOUT_EN
  task automatic test_timeout;
    int h0 = hs_cnt;
    int e0 = err_cnt;
    bus.act_ready = 1'b1;
    send_byte("F");
    idle_cycles(90);
    check_int("tmo_not_yet", int'(bus.busy), 1);
    idle_cycles(15);
    check_int("tmo_err", err_cnt - e0, 1);
    check_int("tmo_busy", int'(bus.busy), 0);
    send_byte(8'h0D);
    idle_cycles(3);
    check_int("tmo_no_action", hs_cnt - h0, 0);
    // Timing out of DISCARD is silent.
    send_byte("Z");
    idle_cycles(110);
    check_int("tmo_discard_err", err_cnt - e0, 2);
    check_int("tmo_discard_busy", int'(bus.busy), 0);
  endtask
`endif

  initial begin
    bus.rx_byte = 8'h00;
    bus.act_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_single;
    test_hold;
    test_error;
    test_reset_mid;
    test_issue_drop;
    test_back_to_back;
`ifdef CMD_PARSER_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
